// File: rtl/capture_reader.sv
// capture_reader: once capture stops, reads the sample RAM oldest-first and streams the
// samples over a valid/ready port. Single clock domain (cfg_clk).
//
//  state  | meaning
//  IDLE   | waiting for rd_start
//  ARM    | readout requested, waiting for stop_flag
//  READ   | issuing RAM reads into the 2-entry output FIFO
//  DRAIN  | all reads issued, emptying the FIFO
//  DONE   | readout complete, done held until rd_start or abort
module capture_reader #(
  parameter int DEPTH  = 5461,
  parameter int DATA_W = 8
) (
  input  logic              cfg_clk,
  input  logic              cfg_rstn,
  input  logic              rd_start,
  input  logic              rd_abort,
  input  logic              stop_flag,
  input  logic              overflow_flag,
  input  logic [15:0]       stop_addr,
  output logic              rd_ce,
  output logic [15:0]       rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [15:0]       sample_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [15:0] LAST_ADDR = 16'(DEPTH - 1);
  localparam logic [15:0] DEPTH_W   = 16'(DEPTH);

  state_t            state, state_nx;
  logic [15:0]       total, issued, addr, sa_clamp;
  logic              inflight;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        fifo_cnt;
  logic [2:0]        occ;
  logic              start_ok, pop, push, last_issue, last_accept;

  // Handshake decode, flow-control window and externally visible outputs.
  // The read window counts this cycle's acceptance as freed space so a steady
  // 1 sample/cycle stream is sustained with out_ready held high.
  always_comb begin
    start_ok    = rd_start && !rd_abort && (state == S_IDLE || state == S_DONE);
    out_valid   = (fifo_cnt != 2'd0);
    out_data    = fifo_mem[rd_ptr];
    pop         = out_valid && out_ready;
    push        = inflight;
    occ         = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
    rd_ce       = (state == S_READ) && !rd_abort && (occ < 3'd2) && (issued != total);
    rd_addr     = addr;
    last_issue  = rd_ce && ((issued + 16'd1) == total);
    last_accept = pop && ((sample_cnt + 16'd1) == total);
    out_last    = out_valid && (sample_cnt == (total - 16'd1));
    busy        = (state == S_ARM) || (state == S_READ) || (state == S_DRAIN);
    done        = (state == S_DONE);
    sa_clamp    = (stop_addr > LAST_ADDR) ? LAST_ADDR : stop_addr;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (rd_start)    state_nx = S_ARM;
      S_ARM:   if (stop_flag)   state_nx = S_READ;
      S_READ:  if (last_issue)  state_nx = S_DRAIN;
      S_DRAIN: if (last_accept) state_nx = S_DONE;
      S_DONE:  if (rd_start)    state_nx = S_ARM;
      default:                  state_nx = S_IDLE;
    endcase
    if (rd_abort) state_nx = S_IDLE;
  end

  // State register.
  always_ff @(posedge cfg_clk or negedge cfg_rstn) begin
    if (!cfg_rstn) state <= S_IDLE;
    else           state <= state_nx;
  end

  // Readout parameters, read address/issue counter and in-flight tracking.
  always_ff @(posedge cfg_clk or negedge cfg_rstn) begin
    if (!cfg_rstn) begin
      total    <= 16'd0;
      issued   <= 16'd0;
      addr     <= 16'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_ce;
      if (state == S_ARM && stop_flag && !rd_abort) begin
        total  <= overflow_flag ? DEPTH_W : sa_clamp + 16'd1;
        addr   <= (overflow_flag && sa_clamp != LAST_ADDR) ? sa_clamp + 16'd1 : 16'd0;
        issued <= 16'd0;
      end else if (rd_ce) begin
        issued <= issued + 16'd1;
        addr   <= (addr == LAST_ADDR) ? 16'd0 : addr + 16'd1;
      end
    end
  end

  // Two-entry output FIFO; abort flushes it and drops any arriving RAM word.
  always_ff @(posedge cfg_clk or negedge cfg_rstn) begin
    if (!cfg_rstn) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else if (rd_abort) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= rd_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Accepted-sample counter, held through DONE until the next readout or abort.
  always_ff @(posedge cfg_clk or negedge cfg_rstn) begin
    if (!cfg_rstn)                 sample_cnt <= 16'd0;
    else if (rd_abort || start_ok) sample_cnt <= 16'd0;
    else if (pop)                  sample_cnt <= sample_cnt + 16'd1;
  end

endmodule

// File: tb/tb_capture_reader.sv
// Bench for capture_reader: RAM model plus scoreboard of expected addresses/samples.
module tb_capture_reader;
  localparam int DEPTH = 16;
  localparam int DW    = 8;

  logic          cfg_clk = 1'b0;
  logic          cfg_rstn, rd_start, rd_abort, stop_flag, overflow_flag, out_ready;
  logic [15:0]   stop_addr, rd_addr, sample_cnt;
  logic          rd_ce, out_valid, out_last, busy, done;
  logic [DW-1:0] rd_data, out_data;

  logic [DW-1:0] ram [DEPTH];
  logic [15:0]   exp_addr_q [$];
  logic [DW-1:0] exp_data_q [$];
  int            n_total = 0;
  int            n_bad   = 0;

  capture_reader #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .cfg_clk(cfg_clk), .cfg_rstn(cfg_rstn), .rd_start(rd_start), .rd_abort(rd_abort),
    .stop_flag(stop_flag), .overflow_flag(overflow_flag), .stop_addr(stop_addr),
    .rd_ce(rd_ce), .rd_addr(rd_addr), .rd_data(rd_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy),
    .done(done), .sample_cnt(sample_cnt)
  );

  always #5 cfg_clk = ~cfg_clk;

  always @(posedge cfg_clk) if (rd_ce) rd_data <= ram[rd_addr[3:0]];

  task automatic preload();
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'(i * 16) | 8'($urandom_range(0, 15));
  endtask

  task automatic test_reset();
    cfg_rstn = 1'b0;
    repeat (3) @(negedge cfg_clk);
    n_total++;
    if ({rd_ce, rd_addr, out_valid, out_last, out_data, busy, done, sample_cnt} !== '0)
      begin n_bad++; $display("FAIL reset_outputs: got ce=%b addr=%0d v=%b l=%b d=%h busy=%b done=%b cnt=%0d want all 0",
                              rd_ce, rd_addr, out_valid, out_last, out_data, busy, done, sample_cnt); end
    cfg_rstn = 1'b1;
    @(negedge cfg_clk);
  endtask

  task automatic run_readout(input string tag, input logic ovf, input logic [15:0] sa_in,
                             input int duty, input int arm_wait);
    int sa, tot, first, got, a;
    logic stall, held_l, finished;
    logic [DW-1:0] held_d, exp_d;
    logic [15:0] ea;
    preload();
    sa    = (int'(sa_in) > DEPTH - 1) ? DEPTH - 1 : int'(sa_in);
    tot   = ovf ? DEPTH : sa + 1;
    first = ovf ? ((sa == DEPTH - 1) ? 0 : sa + 1) : 0;
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int k = 0; k < tot; k++) begin
      a = (first + k) % DEPTH;
      exp_addr_q.push_back(16'(a));
      exp_data_q.push_back(ram[a]);
    end
    stop_flag = (arm_wait == 0); overflow_flag = ovf; stop_addr = sa_in;
    out_ready = 1'b0; rd_start = 1'b1;
    @(negedge cfg_clk);
    rd_start = 1'b0;
    for (int c = 0; c < arm_wait; c++) begin
      n_total++;
      if (rd_ce !== 1'b0 || busy !== 1'b1)
        begin n_bad++; $display("FAIL %s arm_wait: got rd_ce=%b busy=%b want 0 1", tag, rd_ce, busy); end
      @(negedge cfg_clk);
    end
    stop_flag = 1'b1;
    stall = 1'b0; held_d = '0; held_l = 1'b0; got = 0; finished = 1'b0;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      out_ready = ($urandom_range(1, 100) <= duty);
      #1;
      if (rd_ce) begin
        n_total++;
        if (exp_addr_q.size() == 0) begin
          n_bad++; $display("FAIL %s extra_read: got addr=%0d want no read", tag, rd_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          if (rd_addr !== ea) begin n_bad++; $display("FAIL %s rd_addr: got %0d want %0d", tag, rd_addr, ea); end
        end
      end
      if (stall) begin
        n_total++;
        if (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l)
          begin n_bad++; $display("FAIL %s stall_hold: got v=%b d=%h l=%b want 1 %h %b",
                                  tag, out_valid, out_data, out_last, held_d, held_l); end
      end
      if (out_valid && out_ready) begin
        n_total += 2;
        if (exp_data_q.size() == 0) begin
          n_bad += 2; $display("FAIL %s extra_sample: got %h want none", tag, out_data);
        end else begin
          exp_d = exp_data_q.pop_front();
          got++;
          if (out_data !== exp_d) begin n_bad++; $display("FAIL %s data: got %h want %h", tag, out_data, exp_d); end
          if (out_last !== (exp_data_q.size() == 0))
            begin n_bad++; $display("FAIL %s last: got %b want %b (sample %0d)", tag, out_last, exp_data_q.size() == 0, got); end
        end
      end
      stall  = out_valid && !out_ready;
      held_d = out_data;
      held_l = out_last;
      if (done) begin
        finished = 1'b1;
        n_total++;
        if (got != tot) begin n_bad++; $display("FAIL %s done_early: got %0d samples want %0d", tag, got, tot); end
      end
      @(negedge cfg_clk);
    end
    out_ready = 1'b0;
    n_total++;
    if (!finished) begin n_bad++; $display("FAIL %s timeout: got done=0 want done=1", tag); end
    #1;
    n_total++;
    if (sample_cnt !== 16'(tot) || busy !== 1'b0 || done !== 1'b1 || exp_addr_q.size() != 0)
      begin n_bad++; $display("FAIL %s final: got cnt=%0d busy=%b done=%b unread=%0d want %0d 0 1 0",
                              tag, sample_cnt, busy, done, exp_addr_q.size(), tot); end
  endtask

  task automatic test_no_wrap();
    run_readout("no_wrap", 1'b0, 16'd5, 100, 0);
  endtask

  task automatic test_wrap();
    run_readout("wrap", 1'b1, 16'd9, 100, 0);
  endtask

  task automatic test_edge_wrap();
    run_readout("edge_wrap_15", 1'b1, 16'd15, 100, 0);
    run_readout("edge_wrap_40", 1'b1, 16'd40, 100, 0);
  endtask

  task automatic test_backpressure();
    run_readout("bp_wrap", 1'b1, 16'd6, 30, 0);
    run_readout("bp_nowrap", 1'b0, 16'd12, 30, 0);
  endtask

  task automatic test_arm_wait();
    run_readout("arm_wait", 1'b0, 16'd7, 100, 20);
  endtask

  task automatic test_abort(input logic use_reset);
    int acc;
    preload();
    stop_flag = 1'b1; overflow_flag = 1'b0; stop_addr = 16'd10;
    out_ready = 1'b1; rd_start = 1'b1;
    @(negedge cfg_clk);
    rd_start = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 100 && acc < 3; cyc++) begin
      #1;
      if (out_valid && out_ready) acc++;
      @(negedge cfg_clk);
    end
    n_total++;
    if (acc != 3) begin n_bad++; $display("FAIL abort_setup: got %0d acceptances want 3", acc); end
    n_total++;
    if (sample_cnt !== 16'd3) begin n_bad++; $display("FAIL abort_pre_cnt: got %0d want 3", sample_cnt); end
    if (!use_reset) begin
      rd_abort = 1'b1;
      @(negedge cfg_clk);
      rd_abort = 1'b0;
      #1;
      n_total++;
      if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || sample_cnt !== 16'd0 || rd_ce !== 1'b0)
        begin n_bad++; $display("FAIL abort_state: got v=%b done=%b busy=%b cnt=%0d ce=%b want 0 0 0 0 0",
                                out_valid, done, busy, sample_cnt, rd_ce); end
      for (int c = 0; c < 4; c++) begin
        @(negedge cfg_clk);
        #1;
        n_total++;
        if (out_valid !== 1'b0 || rd_ce !== 1'b0)
          begin n_bad++; $display("FAIL abort_quiet: got v=%b ce=%b want 0 0", out_valid, rd_ce); end
      end
    end else begin
      cfg_rstn = 1'b0;
      #1;
      n_total++;
      if ({rd_ce, rd_addr, out_valid, out_last, out_data, busy, done, sample_cnt} !== '0)
        begin n_bad++; $display("FAIL reset_mid: got ce=%b addr=%0d v=%b l=%b d=%h busy=%b done=%b cnt=%0d want all 0",
                                rd_ce, rd_addr, out_valid, out_last, out_data, busy, done, sample_cnt); end
      @(negedge cfg_clk);
      cfg_rstn = 1'b1;
      @(negedge cfg_clk);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    cfg_rstn = 1'b0; rd_start = 1'b0; rd_abort = 1'b0; stop_flag = 1'b0;
    overflow_flag = 1'b0; stop_addr = 16'd0; out_ready = 1'b0; rd_data = '0;
    preload();
    test_reset();
    test_no_wrap();
    test_wrap();
    test_edge_wrap();
    test_backpressure();
    test_arm_wait();
    test_abort(1'b0);
    run_readout("after_abort", 1'b0, 16'd5, 100, 0);
    test_abort(1'b1);
    run_readout("after_reset", 1'b1, 16'd3, 60, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
